// File: rtl/hs_perf_monitor_if.sv
// Signal bundle between the observed HLS handshakes and hs_perf_monitor: ap_ctrl
// taps, freeze/clear controls, statistics readout port and status flags.
interface hs_perf_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_ready;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic              finish;
    logic              clr;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [2:0]        rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;
    logic [NUM_CH-1:0] ch_busy;
    logic              frozen;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, finish, clr, rd_en, rd_ch, rd_sel,
        input  rd_data, rd_valid, ch_busy, frozen
    );

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, finish, clr, rd_en, rd_ch, rd_sel,
        output rd_data, rd_valid, ch_busy, frozen
    );
endinterface

// File: rtl/hs_perf_monitor.sv
// Per-channel HLS block-level handshake profiler: transaction counts, overlapped
// start-to-done latency via a stamp FIFO, stall/busy cycles, freeze and registered readout.
module hs_perf_monitor #(
    parameter int NUM_CH       = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int TS_W         = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    hs_perf_monitor_if.slave bus
);
    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } ch_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [TS_W-1:0]   stamp_r;
    logic              frozen_r;
    logic [CNT_W-1:0]  field_s [NUM_CH];
    logic [NUM_CH-1:0] busy_s;
    logic [4:0]        rd_ch_ext_s;
    logic [CNT_W-1:0]  rd_mux_s;
    logic [CNT_W-1:0]  rd_data_r;
    logic              rd_valid_r;

    // Free-running cycle stamp and sticky freeze request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stamp_r  <= '0;
            frozen_r <= 1'b0;
        end else if (bus.clr) begin
            stamp_r  <= '0;
            frozen_r <= 1'b0;
        end else begin
            if (!frozen_r) begin
                stamp_r <= stamp_r + TS_W'(1);
            end
            frozen_r <= frozen_r | bus.finish;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [TS_W-1:0]  mem_r [MAX_INFLIGHT];
        logic [PTR_W-1:0] wr_ptr_r;
        logic [PTR_W-1:0] rd_ptr_r;
        logic [OCC_W-1:0] occ_r;
        logic [OCC_W-1:0] occ_next_s;
        logic [CNT_W-1:0] starts_r;
        logic [CNT_W-1:0] dones_r;
        logic [CNT_W-1:0] stall_r;
        logic [CNT_W-1:0] busy_r;
        logic [TS_W-1:0]  last_r;
        logic [TS_W-1:0]  min_r;
        logic [TS_W-1:0]  max_r;
        logic [TS_W-1:0]  head_s;
        logic [TS_W-1:0]  lat_s;
        logic             ovf_r;
        logic             unf_r;
        ch_state_t        state_r;
        ch_state_t        state_next_s;
        logic             s_s, d_s, w_s, empty_s, full_s;
        logic             push_s, pop_s, lat_vld_s, ovf_set_s, unf_set_s;
        logic [CNT_W-1:0] fld_s;

        assign head_s = mem_r[rd_ptr_r];

        // Event decode, FIFO action, latency and next channel state
        always_comb begin
            s_s       = bus.ap_start[g] & bus.ap_ready[g];
            d_s       = bus.ap_done[g] & bus.ap_continue[g];
            w_s       = bus.ap_done[g] & ~bus.ap_continue[g];
            empty_s   = (occ_r == '0);
            full_s    = (occ_r == OCC_FULL);
            push_s    = 1'b0;
            pop_s     = 1'b0;
            lat_vld_s = 1'b0;
            lat_s     = '0;
            ovf_set_s = 1'b0;
            unf_set_s = 1'b0;
            if (d_s) begin
                if (!empty_s) begin
                    // A same-cycle start reuses the slot being freed, so it never overflows
                    pop_s     = 1'b1;
                    push_s    = s_s;
                    lat_vld_s = 1'b1;
                    lat_s     = stamp_r - head_s;
                end else if (s_s) begin
                    lat_vld_s = 1'b1;
                end else begin
                    unf_set_s = 1'b1;
                end
            end else if (s_s) begin
                if (full_s) begin
                    ovf_set_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end else begin
                push_s = 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   occ_next_s = occ_r + OCC_W'(1);
                2'b01:   occ_next_s = occ_r - OCC_W'(1);
                default: occ_next_s = occ_r;
            endcase
            if (occ_next_s == '0) begin
                state_next_s = ST_IDLE;
            end else if (w_s) begin
                state_next_s = ST_STALL;
            end else if (d_s || (state_r == ST_IDLE)) begin
                state_next_s = ST_ACTIVE;
            end else begin
                state_next_s = state_r;
            end
        end

        // Timestamp storage; contents are only read while occupancy is non-zero
        always_ff @(posedge clock) begin
            if (push_s && !frozen_r && !bus.clr) begin
                mem_r[wr_ptr_r] <= stamp_r;
            end
        end

        // Channel state machine, pointers, counters and sticky flags
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                occ_r    <= '0;
                starts_r <= '0;
                dones_r  <= '0;
                stall_r  <= '0;
                busy_r   <= '0;
                last_r   <= '0;
                min_r    <= '1;
                max_r    <= '0;
                ovf_r    <= 1'b0;
                unf_r    <= 1'b0;
                state_r  <= ST_IDLE;
            end else if (bus.clr) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                occ_r    <= '0;
                starts_r <= '0;
                dones_r  <= '0;
                stall_r  <= '0;
                busy_r   <= '0;
                last_r   <= '0;
                min_r    <= '1;
                max_r    <= '0;
                ovf_r    <= 1'b0;
                unf_r    <= 1'b0;
                state_r  <= ST_IDLE;
            end else if (!frozen_r) begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                occ_r   <= occ_next_s;
                state_r <= state_next_s;
                if (s_s) begin
                    starts_r <= sat_inc(starts_r);
                end
                if (d_s) begin
                    dones_r <= sat_inc(dones_r);
                end
                if (w_s) begin
                    stall_r <= sat_inc(stall_r);
                end
                if (!empty_s) begin
                    busy_r <= sat_inc(busy_r);
                end
                if (lat_vld_s) begin
                    last_r <= lat_s;
                    if (lat_s < min_r) begin
                        min_r <= lat_s;
                    end
                    if (lat_s > max_r) begin
                        max_r <= lat_s;
                    end
                end
                ovf_r <= ovf_r | ovf_set_s;
                unf_r <= unf_r | unf_set_s;
            end
        end

        // Field select for this channel
        always_comb begin
            case (bus.rd_sel)
                3'd0:    fld_s = starts_r;
                3'd1:    fld_s = dones_r;
                3'd2:    fld_s = CNT_W'(last_r);
                3'd3:    fld_s = CNT_W'(min_r);
                3'd4:    fld_s = CNT_W'(max_r);
                3'd5:    fld_s = stall_r;
                3'd6:    fld_s = busy_r;
                3'd7:    fld_s = CNT_W'({occ_r, unf_r, ovf_r});
                default: fld_s = '0;
            endcase
        end

        assign field_s[g] = fld_s;
        assign busy_s[g]  = (state_r != ST_IDLE);
    end

    assign rd_ch_ext_s = 5'(bus.rd_ch);

    // Channel select; unpopulated channel numbers read as zero
    always_comb begin
        rd_mux_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_mux_s = (rd_ch_ext_s == 5'(i)) ? field_s[i] : rd_mux_s;
        end
    end

    // Registered readout port
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else if (bus.clr) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_r <= rd_mux_s;
            end
        end
    end

    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.ch_busy  = busy_s;
    assign bus.frozen   = frozen_r;
endmodule

// File: doc/hs_perf_monitor.md
Name: hs_perf_monitor

Overview:
- Synthesizable, parametrised successor to the per-module ap_start/ap_ready/ap_done status monitors.
- Observes NUM_CH HLS block-level handshakes (ap_ctrl_chain style) in parallel.
- Per channel, it counts transactions, measures start-to-done latency with up to MAX_INFLIGHT overlapped (pipelined) transactions, and accumulates stall and busy cycles.
- Statistics are frozen on finish and read out through a registered select port, for on-chip profiling beside the DUT.

Parameters:
- NUM_CH, 4, number of monitored handshake channels (1..16).
- MAX_INFLIGHT, 4, per-channel timestamp FIFO depth (power of 2, ≥2).
- TS_W, 16, width of the free-running cycle stamp and of latency values.
- CNT_W, 32, width of statistic counters and rd_data (must be ≥ TS_W).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  NUM_CH  per-channel start.
- ap_ready  in  NUM_CH  per-channel ready.
- ap_done  in  NUM_CH  per-channel done.
- ap_continue  in  NUM_CH  per-channel continue; tie to 1 for ap_ctrl_hs channels.
- finish  in  1  freeze request; sticky until clr.
- clr  in  1  synchronous clear of all statistics, flags and the freeze.
- rd_en  in  1  read request.
- rd_ch  in  $clog2(NUM_CH) (min 1)  channel select.
- rd_sel  in  3  field select.
- rd_data  out  CNT_W  read data.
- rd_valid  out  1  rd_data valid.
- ch_busy  out  NUM_CH  channel has ≥1 transaction in flight.
- frozen  out  1  statistics frozen.

Behaviour:
- Reset (reset=0): all counters 0; min_lat = all-ones (TS_W); FIFOs empty; flags 0; rd_data 0; rd_valid 0; ch_busy 0; frozen 0; cycle stamp 0.
- clr: same effect as reset, in one cycle. clr wins over every simultaneous event.
- Cycle stamp: TS_W-bit counter, +1 every cycle while not frozen; wraps modulo 2^TS_W.
- Events, per channel i:
  - S = ap_start & ap_ready.
  - D = ap_done & ap_continue.
  - W = ap_done & ~ap_continue.
- Per channel, while not frozen:
  - S: starts+1; push stamp unless FIFO full. If full, set ovf (sticky) and drop the stamp.
  - D with FIFO non-empty: pop head; lat = (stamp − head) mod 2^TS_W; dones+1; update last/min/max.
  - D with FIFO empty and S the same cycle: zero-latency transaction; lat = 0; no push or pop; dones+1.
  - D with FIFO empty and no S: dones+1; set unf (sticky); no latency update.
  - S and D together with FIFO non-empty: pop head for D and push the new stamp in the same cycle. Occupancy is unchanged and ovf is never set in this case.
  - W: stall+1.
  - busy+1 every cycle the FIFO is non-empty.
- Channel state machine (combinational outputs from FIFO count and W):
  - IDLE (count 0) → ACTIVE on push.
  - ACTIVE → STALL when W.
  - STALL → ACTIVE on D (or IDLE if count reaches 0).
  - ACTIVE → IDLE on the pop that empties the FIFO.
  - ch_busy = state ≠ IDLE.
- Saturation: every CNT_W counter saturates at all-ones and does not wrap.
- Freeze: finish high for one cycle sets frozen, effective from the next cycle. While frozen, stamp, counters, FIFOs and flags hold and handshake inputs are ignored. Readout still works.
- Readout: 1-cycle latency. On rd_en in cycle N, rd_valid=1 and rd_data are valid in cycle N+1; otherwise rd_valid=0 and rd_data holds.
  - rd_ch ≥ NUM_CH returns 0.
  - Latency fields are zero-extended to CNT_W.
- rd_sel fields:
  - 0: starts.
  - 1: dones.
  - 2: last_lat.
  - 3: min_lat (all-ones TS_W if no latency recorded yet).
  - 4: max_lat.
  - 5: stall cycles.
  - 6: busy cycles.
  - 7: {zeros, inflight count, unf, ovf}, with ovf at bit0.
- Channels are fully independent. There is no cross-channel arbitration.

Test Plan:
- Single channel, ctrl_hs:
  - Stimulus: S at cycle 10, D at cycle 17.
  - Required: starts=1, dones=1, last=min=max=7, busy=7.
  - ch_busy high cycles 11–17.
- Pipelined channel:
  - Stimulus: S at cycles 5, 6, 7; D at 12, 13, 15.
  - Required: latencies 7, 7, 8; min=7, max=8, dones=3.
  - inflight is 3 at cycle 8.
- Overflow and underflow:
  - Stimulus: 5 S with no D, MAX_INFLIGHT=4. Required: ovf=1, starts=5, inflight=4.
  - Stimulus: D on an empty FIFO. Required: unf=1, dones increments, last_lat unchanged.
- Stall and zero latency:
  - Stimulus: ap_done=1 with ap_continue=0 for 3 cycles, then continue. Required: stall=3, single pop.
  - Stimulus: S and D in the same cycle on an empty FIFO. Required: last_lat=0.
- Freeze, clear and reset:
  - Stimulus: finish, then 20 further events. Required: counters unchanged; reads return the frozen values.
  - Stimulus: clr. Required: all fields 0, min=0xFFFF, frozen=0.
  - Stimulus: reset asserted mid-transaction. Required: outputs 0 immediately (asynchronously).
- Wrap and saturation:
  - Stimulus: TS_W=4, S at stamp 14, D at stamp 3. Required: lat=5.
  - Stimulus: CNT_W=8, 300 starts. Required: starts=255.
